// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: digit count,
// active-low glyph patterns ordered {g,f,e,d,c,b,a}, and blank codes.
package seg7_pkg;

    localparam int NDIG = 8;

    localparam logic [6:0] GLYPH_0    = 7'b1000000;
    localparam logic [6:0] GLYPH_1    = 7'b1111001;
    localparam logic [6:0] GLYPH_2    = 7'b0100100;
    localparam logic [6:0] GLYPH_3    = 7'b0110000;
    localparam logic [6:0] GLYPH_4    = 7'b0011001;
    localparam logic [6:0] GLYPH_5    = 7'b0010010;
    localparam logic [6:0] GLYPH_6    = 7'b0000010;
    localparam logic [6:0] GLYPH_7    = 7'b1111000;
    localparam logic [6:0] GLYPH_8    = 7'b0000000;
    localparam logic [6:0] GLYPH_9    = 7'b0010000;
    localparam logic [6:0] GLYPH_DASH = 7'b0111111;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-glyph lookup; values 10..15 are not BCD and
// show a dash so a bad upstream conversion is visible on the display.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    // Map one BCD digit to its active-low segment pattern
    always_comb begin
        glyph = GLYPH_DASH;
        case (value)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit common-anode display driver. The BCD word and
// decimal-point mask are captured once per frame so a frame never tears.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_HZ  = 25_000_000,
    parameter int SCAN_HZ = 1_000
) (
    input  logic                 clk_25MHz,
    input  logic                 rst_n,
    input  logic [4*NDIG-1:0]    dec,
    input  logic [NDIG-1:0]      dp_mask,
    output logic [NDIG-1:0]      an,
    output logic [7:0]           seg,
    output logic                 frame_done
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic [PW-1:0]     pcnt;
    logic [2:0]        idx;
    logic [2:0]        next_idx;
    logic              tick;
    logic              load;
    logic [4*NDIG-1:0] snap_dec;
    logic [NDIG-1:0]   snap_dp;
    logic [4*NDIG-1:0] cur_dec;
    logic [NDIG-1:0]   cur_dp;
    logic [3:0]        digit_val;
    logic [6:0]        glyph;

    assign tick = (pcnt == PMAX);

    // Select the digit about to be shown; on the load edge bypass the snapshot
    always_comb begin
        next_idx  = idx + 3'd1;
        load      = tick && (next_idx == 3'd0);
        cur_dec   = load ? dec : snap_dec;
        cur_dp    = load ? dp_mask : snap_dp;
        digit_val = cur_dec[{next_idx, 2'b00} +: 4];
    end

`ifdef SEG7_LZ_BLANK_EN
    logic blank;

    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        blank = (next_idx != 3'd0) && ((cur_dec >> {next_idx, 2'b00}) == '0);
    end
`endif

    seg7_decode u_decode (
        .value (digit_val),
        .glyph (glyph)
    );

    // Prescaler and digit index: advance one slot every DIV cycles
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= 3'd7;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx <= next_idx;
            end
        end
    end

    // Frame snapshot and registered display outputs, refreshed on each tick
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            snap_dec   <= '0;
            snap_dp    <= '0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= load;
            if (load) begin
                snap_dec <= dec;
                snap_dp  <= dp_mask;
            end
            if (tick) begin
`ifdef SEG7_LZ_BLANK_EN
                if (blank) begin
                    an  <= AN_OFF;
                    seg <= SEG_OFF;
                end else begin
                    an  <= ~(NDIG'(1) << next_idx);
                    seg <= {~cur_dp[next_idx], glyph};
                end
`else
                an  <= ~(NDIG'(1) << next_idx);
                seg <= {~cur_dp[next_idx], glyph};
`endif
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan with DIV=4. A cycle-level reference model
// derives every expected output from the number of clock edges since reset
// release and pushes it into a queue; a monitor pops and compares each cycle.
module tb_seg7_scan;

    localparam int CLK_HZ  = 8;
    localparam int SCAN_HZ = 2;
    localparam int DIV     = CLK_HZ / SCAN_HZ;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    logic        clk_25MHz = 1'b0;
    logic        rst_n     = 1'b0;
    logic [31:0] dec       = '0;
    logic [7:0]  dp_mask   = '0;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    exp_t expQ[$];

    // Independent glyph table, active-low {g,f,e,d,c,b,a}, 10..15 = dash
    logic [6:0] glyphTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                  7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h3F,
                                  7'h3F, 7'h3F, 7'h3F, 7'h3F};

    seg7_scan #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ)
    ) dut (
        .clk_25MHz  (clk_25MHz),
        .rst_n      (rst_n),
        .dec        (dec),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk_25MHz = ~clk_25MHz;

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [7:0] m,
                                 input int cycles);
        dec     = d;
        dp_mask = m;
        repeat (cycles) @(negedge clk_25MHz);
    endtask

    // Reference model state
    int          edgeCount = 0;
    int          slot;
    int          digit;
    logic [3:0]  nib;
    logic        blankExp;
    logic [31:0] snapDec = '0;
    logic [7:0]  snapDp  = '0;
    exp_t        cur = '{an: 8'hFF, seg: 8'hFF, fd: 1'b0};

    // Anything queued before an asynchronous reset is stale
    always @(negedge rst_n) expQ.delete();

    // Reference model: slot s = edges/DIV, shown digit is (s-1) mod 8
    always @(posedge clk_25MHz) begin
        if (!rst_n) begin
            edgeCount = 0;
            snapDec   = '0;
            snapDp    = '0;
            cur       = '{an: 8'hFF, seg: 8'hFF, fd: 1'b0};
        end else begin
            edgeCount++;
            cur.fd = 1'b0;
            if (edgeCount % DIV == 0) begin
                slot  = edgeCount / DIV;
                digit = (slot - 1) % 8;
                if (digit == 0) begin
                    snapDec = dec;
                    snapDp  = dp_mask;
                    cur.fd  = 1'b1;
                end
                nib = 4'((snapDec >> (4 * digit)) & 32'hF);
`ifdef SEG7_LZ_BLANK_EN
                blankExp = (digit != 0) && ((snapDec >> (4 * digit)) == 32'd0);
`else
                blankExp = 1'b0;
`endif
                if (blankExp) begin
                    cur.an  = 8'hFF;
                    cur.seg = 8'hFF;
                end else begin
                    cur.an  = ~(8'd1 << digit);
                    cur.seg = {~snapDp[digit], glyphTab[nib]};
                end
            end
        end
        expQ.push_back(cur);
    end

    // Monitor: compare DUT outputs against the oldest expected entry
    exp_t e;
    always @(negedge clk_25MHz) begin
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("an", an, e.an);
            checkOutput("seg", seg, e.seg);
            checkOutput("frame_done", {7'd0, frame_done}, {7'd0, e.fd});
            checkOutput("an_single_low", {7'd0, ($countones(~an) <= 1)}, 8'd1);
        end
    end

    logic [31:0] rndDec;

    initial begin
        rst_n   = 1'b0;
        dec     = '0;
        dp_mask = '0;
        repeat (3) @(negedge clk_25MHz);
        checkOutput("reset_an", an, 8'hFF);
        checkOutput("reset_seg", seg, 8'hFF);
        checkOutput("reset_frame_done", {7'd0, frame_done}, 8'd0);
        rst_n = 1'b1;

        // First frame, then a mid-frame change that must stay hidden
        applyStimulus(32'h1234_5678, 8'h00, 10);
        applyStimulus(32'h0000_0009, 8'h00, 30);
        applyStimulus(32'h0000_0042, 8'h02, 64);
        applyStimulus(32'hA000_000F, 8'h81, 64);
        applyStimulus(32'h0000_0000, 8'h00, 64);
        applyStimulus(32'h1234_5678, 8'hFF, 45);

        // Asynchronous reset mid-frame: outputs must clear without a clock
        @(posedge clk_25MHz);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_an", an, 8'hFF);
        checkOutput("async_reset_seg", seg, 8'hFF);
        checkOutput("async_reset_frame_done", {7'd0, frame_done}, 8'd0);
        @(posedge clk_25MHz);
        @(negedge clk_25MHz);
        rst_n = 1'b1;
        applyStimulus(32'h8765_4321, 8'h10, 40);

        // Randomised BCD words, some illegal digits, varied leading zeros
        for (int i = 0; i < 24; i++) begin
            rndDec = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (rndDec[4*k +: 4] > 4'd9) rndDec[4*k +: 4] = 4'($urandom_range(0, 9));
                end
            end
            rndDec = rndDec & (32'hFFFF_FFFF >> (4 * $urandom_range(0, 7)));
            applyStimulus(rndDec, 8'($urandom), $urandom_range(1, 40));
        end
        applyStimulus(32'h0000_0100, 8'h00, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
